pill_duration_tracker: RTL and testbench
========================================

Name: pill_duration_tracker

Overview:
Upstream feeder of the LCD controller. Latches the patient record word, counts down a dosing interval for each of three pills, and drives the per-pill remaining-time digits that the LCD shows on line 2. It also raises per-pill due and overdue flags for the buzzer and LED logic. One instance sits between the patient ROM and the LCD controller in the top level.

Parameters:
TICKS_PER_UNIT, 400, CLK_400Hz cycles per countdown unit (400 = 1 s; the bench uses 4).
OVERDUE_UNITS, 5, units a pill may stay due before its overdue flag sets.

Ports:
CLK_400Hz  input  1  system clock
resetn  input  1  asynchronous active-low reset
romContent  input  28  patient record: [27:24] patient id, [23:20] pill1 id, [19:16] pill1 interval, [15:12] pill2 id, [11:8] pill2 interval, [7:4] pill3 id, [3:0] pill3 interval
load  input  1  single-cycle pulse; latch romContent and restart all timers
ack  input  3  single-cycle per-pill "dose taken" pulses; bit0 = pill1
pill12And3Duration  output  12  remaining units as digits: [11:8] pill1, [7:4] pill2, [3:0] pill3; each digit 0..9
due  output  3  pill interval expired and not yet acknowledged
overdue  output  3  due held for at least OVERDUE_UNITS units
alarm  output  1  OR of due
active  output  1  a record has been loaded since reset

Behaviour:
- Reset is asynchronous, active-low, on resetn; clock is CLK_400Hz. All registers clear: state IDLE, pill12And3Duration=0, due=0, overdue=0, alarm=0, active=0, prescaler=0.
- States:
  - IDLE: ack is ignored and the prescaler is held at 0. load moves to RUN.
  - RUN: counts down. A further load restarts the record and all timers (reload in place, stays RUN).
- Load, one cycle latency. On the edge where load=1:
  - Intervals latch from romContent.
  - Each counter = min(interval, 9). A raw interval above 9 clamps to 9.
  - Prescaler = 0, due = 0, overdue counters and flags = 0, active = 1.
  - New values are visible after that edge.
- Prescaler:
  - Counts 0..TICKS_PER_UNIT-1 in RUN only.
  - unit_tick is true on the cycle where the count equals TICKS_PER_UNIT-1; the count wraps to 0 on that edge.
  - The first tick after load therefore falls TICKS_PER_UNIT cycles after the load edge.
- Per pill i, priority load > ack > tick:
  - Interval 0: pill disabled. Digit stays 0, due and overdue never set, ack ignored.
  - On unit_tick with counter>0 and due[i]=0: counter decrements. If it goes 1→0, due[i] sets on the same edge.
  - On unit_tick with due[i]=1: overdue count increments, saturating at OVERDUE_UNITS. It reaching OVERDUE_UNITS sets overdue[i].
  - ack[i] with due[i]=1: counter reloads to its clamped interval; due[i], overdue[i] and the overdue count clear. This also applies if a tick occurs on the same cycle; ack wins.
  - ack[i] with due[i]=0: ignored, with no early reset.
  - Simultaneous acks on several pills are handled independently.
- Outputs:
  - pill12And3Duration is the registered counter values. Each is 4-bit binary 0..9, which the LCD renders as an ASCII digit.
  - alarm is the registered OR of due, matching due timing.
- load and ack are synchronous and are already debounced/pulsed upstream. A held-high load re-reloads every cycle, which is legal and keeps the timers frozen at full interval.
- resetn asserted mid-operation returns to IDLE immediately, regardless of state.

Decomposition:
- Shared package pill_pkg: record field offsets/widths (PATIENT_MSB=27, PILL1_INT=19:16, etc.), DIGIT_MAX=9, state encodings IDLE/RUN.
- Sub-module pill_timer, instantiated 3x:
  - Inputs: clk, resetn, load, interval[3:0], unit_tick, ack.
  - Outputs: count[3:0], due, overdue.
- The top holds the prescaler, state, the active flag and output packing.

Test Plan:
1. Reset, then romContent=28'h1_1_3_2_5_3_0. Pulse load. → digits 3/5/0 appear the cycle after; active=1, due=0. With TICKS_PER_UNIT=4, after 12 cycles → pill1 digit 0 and due=3'b001, alarm=1. Pill3 never goes due.
2. Interval nibble 4'hC on pill2. → digit clamps to 9 and counts 9→0 over 9 units.
3. Pill1 due, hold with no ack for 5 units. → overdue[0]=1 exactly at the 5th tick. Pulse ack[0] → due[0]=0, overdue[0]=0, digit reloads to 3.
4. Edge cases on ack:
  - ack[1] while pill2 is not due → ignored, countdown continues.
  - ack[0] on the same cycle as a unit_tick while due → reload wins and the digit shows 3, not 2.
5. Mid-countdown load with new romContent intervals 7/7/7 → all digits 7, due cleared, prescaler restarts (next tick 4 cycles later). Load coincident with ack → load result.
6. Assert resetn low mid-RUN with due≠0 → all outputs 0 asynchronously. With no load afterwards, ack pulses produce no change (IDLE).

Source files
------------

// File: rtl/pill_pkg.sv
// Shared definitions for the pill tracker: record field positions, digit limit and state encodings.
// Also holds the clamp helper that turns a raw interval nibble into a displayable digit.
package pill_pkg;

  localparam int PATIENT_MSB   = 27;
  localparam int PATIENT_LSB   = 24;
  localparam int PILL1_ID_MSB  = 23;
  localparam int PILL1_ID_LSB  = 20;
  localparam int PILL1_INT_MSB = 19;
  localparam int PILL1_INT_LSB = 16;
  localparam int PILL2_ID_MSB  = 15;
  localparam int PILL2_ID_LSB  = 12;
  localparam int PILL2_INT_MSB = 11;
  localparam int PILL2_INT_LSB = 8;
  localparam int PILL3_ID_MSB  = 7;
  localparam int PILL3_ID_LSB  = 4;
  localparam int PILL3_INT_MSB = 3;
  localparam int PILL3_INT_LSB = 0;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The LCD shows one decimal digit per pill, so longer intervals saturate at 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return (v > DIGIT_MAX) ? DIGIT_MAX : v;
  endfunction

endpackage

// File: rtl/pill_duration_tracker_if.sv
// Record/control inputs and display/alert outputs of the pill tracker.
// The tracker takes the slave side; the ROM/button logic (or a bench) takes the master side.
interface pill_duration_tracker_if;
  logic [27:0] romContent;
  logic        load;
  logic [2:0]  ack;
  logic [11:0] pill12And3Duration;
  logic [2:0]  due;
  logic [2:0]  overdue;
  logic        alarm;
  logic        active;

  modport master (
    output romContent, load, ack,
    input  pill12And3Duration, due, overdue, alarm, active
  );

  modport slave (
    input  romContent, load, ack,
    output pill12And3Duration, due, overdue, alarm, active
  );
endinterface

// File: rtl/pill_timer.sv
// One pill's countdown: priority load > ack > unit tick; due on the 1->0 step, overdue after OVERDUE_UNITS more ticks.
// Zero interval disables the pill, since due is only raised by a 1->0 decrement.
module pill_timer
  import pill_pkg::*;
#(
  parameter int OVERDUE_UNITS = 5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [3:0] interval,
  input  logic       unit_tick,
  input  logic       ack,
  output logic [3:0] count,
  output logic       due,
  output logic       overdue
);

  localparam int OVW = $clog2(OVERDUE_UNITS + 1);

  logic [3:0]     r_reload;
  logic [3:0]     r_count;
  logic           r_due;
  logic           r_overdue;
  logic [OVW-1:0] r_ovc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_reload  <= '0;
      r_count   <= '0;
      r_due     <= 1'b0;
      r_overdue <= 1'b0;
      r_ovc     <= '0;
    end else if (load) begin
      r_reload  <= clamp_digit(interval);
      r_count   <= clamp_digit(interval);
      r_due     <= 1'b0;
      r_overdue <= 1'b0;
      r_ovc     <= '0;
    end else if (ack && r_due) begin
      r_count   <= r_reload;
      r_due     <= 1'b0;
      r_overdue <= 1'b0;
      r_ovc     <= '0;
    end else if (unit_tick) begin
      if (r_due) begin
        if (r_ovc != OVW'(OVERDUE_UNITS))
          r_ovc <= r_ovc + OVW'(1);
        if (r_ovc == OVW'(OVERDUE_UNITS - 1))
          r_overdue <= 1'b1;
      end else if (r_count != 4'd0) begin
        r_count <= r_count - 4'd1;
        if (r_count == 4'd1)
          r_due <= 1'b1;
      end
    end
  end

  assign count   = r_count;
  assign due     = r_due;
  assign overdue = r_overdue;

endmodule

// File: rtl/pill_duration_tracker.sv
// Latches the patient record, runs the unit prescaler and three pill timers, and packs digits/flags for the LCD and buzzer.
// Load takes effect one edge after it is sampled; ack is only honoured while RUN.
module pill_duration_tracker
  import pill_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 400,
  parameter int OVERDUE_UNITS  = 5
) (
  input  logic                    CLK_400Hz,
  input  logic                    resetn,
  pill_duration_tracker_if.slave  bus
);

  localparam int PW = $clog2(TICKS_PER_UNIT + 1);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_active;

  logic          w_run;
  logic          w_tick;
  logic [3:0]    w_interval [3];
  logic [3:0]    w_count    [3];
  logic [2:0]    w_due;
  logic [2:0]    w_overdue;

  assign w_run  = (r_state == RUN);
  assign w_tick = w_run && (r_presc == PW'(TICKS_PER_UNIT - 1));

  // Any load, including one that arrives in RUN, restarts the unit phase.
  always_ff @(posedge CLK_400Hz or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_presc  <= '0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_presc <= '0;
          if (bus.load) begin
            r_state  <= RUN;
            r_active <= 1'b1;
          end
        end
        RUN: begin
          if (bus.load || w_tick)
            r_presc <= '0;
          else
            r_presc <= r_presc + PW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_interval[0] = bus.romContent[PILL1_INT_MSB:PILL1_INT_LSB];
  assign w_interval[1] = bus.romContent[PILL2_INT_MSB:PILL2_INT_LSB];
  assign w_interval[2] = bus.romContent[PILL3_INT_MSB:PILL3_INT_LSB];

  for (genvar g = 0; g < 3; g++) begin : g_pill
    pill_timer #(
      .OVERDUE_UNITS (OVERDUE_UNITS)
    ) u_timer (
      .clk       (CLK_400Hz),
      .resetn    (resetn),
      .load      (bus.load),
      .interval  (w_interval[g]),
      .unit_tick (w_tick),
      .ack       (bus.ack[g] & w_run),
      .count     (w_count[g]),
      .due       (w_due[g]),
      .overdue   (w_overdue[g])
    );
  end

  assign bus.pill12And3Duration = {w_count[0], w_count[1], w_count[2]};
  assign bus.due                = w_due;
  assign bus.overdue            = w_overdue;
  // OR of the due flops, so alarm moves on exactly the same edge as due.
  assign bus.alarm              = |w_due;
  assign bus.active             = r_active;

endmodule

// File: tb/tb_pill_duration_tracker.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with a cycle number; a negedge monitor pops and compares.
module tb_pill_duration_tracker;

  logic CLK_400Hz;
  logic resetn;
  int   cyc;
  bit   done;
  int   checks;
  int   failures;

  pill_duration_tracker_if bus ();

  pill_duration_tracker #(
    .TICKS_PER_UNIT (4),
    .OVERDUE_UNITS  (5)
  ) dut (
    .CLK_400Hz (CLK_400Hz),
    .resetn    (resetn),
    .bus       (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [19:0] exp;
  } exp_t;

  exp_t q[$];

  initial begin
    CLK_400Hz = 1'b0;
    forever #5 CLK_400Hz = ~CLK_400Hz;
  end

  initial cyc = 0;
  always @(posedge CLK_400Hz) cyc <= cyc + 1;

  task automatic step();
    @(posedge CLK_400Hz);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_at(input int c, input string nm, input logic [11:0] dig,
                           input logic [2:0] du, input logic [2:0] ov,
                           input logic al, input logic ac);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.exp  = {dig, du, ov, al, ac};
    q.push_back(e);
  endtask

  task automatic pulse_load(input logic [27:0] rec, input logic [2:0] ack_v, output int l);
    bus.romContent = rec;
    bus.ack        = ack_v;
    bus.load       = 1'b1;
    step();
    bus.load = 1'b0;
    bus.ack  = 3'b000;
    l        = cyc;
  endtask

  task automatic pulse_ack_at(input int c, input logic [2:0] a);
    run_to(c - 1);
    bus.ack = a;
    step();
    bus.ack = 3'b000;
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [19:0] act;
    checks   = 0;
    failures = 0;
    while (!done) begin
      @(negedge CLK_400Hz);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = {bus.pill12And3Duration, bus.due, bus.overdue, bus.alarm, bus.active};
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          failures++;
          $display("FAIL %s cyc=%0d(exp %0d) got dig=%h due=%b ov=%b alarm=%b active=%b want dig=%h due=%b ov=%b alarm=%b active=%b",
                   e.name, cyc, e.cyc, act[19:8], act[7:5], act[4:2], act[1], act[0],
                   e.exp[19:8], e.exp[7:5], e.exp[4:2], e.exp[1], e.exp[0]);
        end
      end
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
    $fatal(1);
  end

  // Stimulus
  initial begin
    int l1, l2, l3;
    done           = 1'b0;
    resetn         = 1'b0;
    bus.load       = 1'b0;
    bus.ack        = 3'b000;
    bus.romContent = 28'h0;
    step();
    step();
    expect_at(cyc, "reset", 12'h000, 3'b000, 3'b000, 1'b0, 1'b0);
    step();
    resetn = 1'b1;
    bus.ack = 3'b111;
    step();
    bus.ack = 3'b000;
    expect_at(cyc, "idle_ack", 12'h000, 3'b000, 3'b000, 1'b0, 1'b0);
    step();

    // Intervals 3/5/0: pill1 due after 3 units, pill3 disabled
    pulse_load(28'h1132530, 3'b000, l1);
    expect_at(l1 + 0,  "load_digits",   12'h350, 3'b000, 3'b000, 1'b0, 1'b1);
    expect_at(l1 + 3,  "pre_tick",      12'h350, 3'b000, 3'b000, 1'b0, 1'b1);
    expect_at(l1 + 4,  "tick1",         12'h240, 3'b000, 3'b000, 1'b0, 1'b1);
    expect_at(l1 + 7,  "ack_not_due",   12'h240, 3'b000, 3'b000, 1'b0, 1'b1);
    expect_at(l1 + 8,  "tick2",         12'h130, 3'b000, 3'b000, 1'b0, 1'b1);
    expect_at(l1 + 11, "pre_due",       12'h130, 3'b000, 3'b000, 1'b0, 1'b1);
    expect_at(l1 + 12, "pill1_due",     12'h020, 3'b001, 3'b000, 1'b1, 1'b1);
    expect_at(l1 + 16, "due_hold",      12'h010, 3'b001, 3'b000, 1'b1, 1'b1);
    expect_at(l1 + 20, "pill2_due",     12'h000, 3'b011, 3'b000, 1'b1, 1'b1);
    expect_at(l1 + 31, "pre_overdue",   12'h000, 3'b011, 3'b000, 1'b1, 1'b1);
    expect_at(l1 + 32, "overdue1",      12'h000, 3'b011, 3'b001, 1'b1, 1'b1);
    expect_at(l1 + 36, "ack_beats_tick",12'h300, 3'b010, 3'b000, 1'b1, 1'b1);
    expect_at(l1 + 40, "overdue2",      12'h200, 3'b010, 3'b010, 1'b1, 1'b1);
    pulse_ack_at(l1 + 6, 3'b010);
    pulse_ack_at(l1 + 36, 3'b001);
    run_to(l1 + 41);

    // Reload 7/7/7 mid-run with simultaneous acks: load wins, prescaler restarts
    pulse_load(28'h2172737, 3'b011, l2);
    expect_at(l2 + 0, "reload_777",     12'h777, 3'b000, 3'b000, 1'b0, 1'b1);
    expect_at(l2 + 3, "presc_restart",  12'h777, 3'b000, 3'b000, 1'b0, 1'b1);
    expect_at(l2 + 4, "reload_tick",    12'h666, 3'b000, 3'b000, 1'b0, 1'b1);
    run_to(l2 + 5);

    // Pill2 interval 0xC clamps to 9
    pulse_load(28'h3112C30, 3'b000, l3);
    expect_at(l3 + 0,  "clamp_load",    12'h190, 3'b000, 3'b000, 1'b0, 1'b1);
    expect_at(l3 + 4,  "clamp_tick",    12'h080, 3'b001, 3'b000, 1'b1, 1'b1);
    expect_at(l3 + 23, "clamp_mid",     12'h040, 3'b001, 3'b000, 1'b1, 1'b1);
    expect_at(l3 + 24, "clamp_overdue", 12'h030, 3'b001, 3'b001, 1'b1, 1'b1);
    expect_at(l3 + 35, "clamp_pre0",    12'h010, 3'b001, 3'b001, 1'b1, 1'b1);
    expect_at(l3 + 36, "clamp_zero",    12'h000, 3'b011, 3'b001, 1'b1, 1'b1);
    run_to(l3 + 37);

    // Asynchronous reset while due is set, then acks in IDLE change nothing
    resetn = 1'b0;
    expect_at(cyc, "async_reset", 12'h000, 3'b000, 3'b000, 1'b0, 1'b0);
    step();
    step();
    resetn = 1'b1;
    step();
    bus.ack = 3'b111;
    step();
    bus.ack = 3'b000;
    expect_at(cyc,     "post_reset_ack",  12'h000, 3'b000, 3'b000, 1'b0, 1'b0);
    expect_at(cyc + 5, "post_reset_idle", 12'h000, 3'b000, 3'b000, 1'b0, 1'b0);
    run_to(cyc + 6);
    done = 1'b1;
  end

endmodule
